// File: rtl/seg_pkg.sv
// Shared constants for the serial 7-segment frame receiver: frame size,
// active-low hex glyph table and the receive FSM state encoding.
package seg_pkg;

    localparam int FRAME_BITS = 64;

    // Active-low {g,f,e,d,c,b,a} for hex digits 0..F
    localparam logic [6:0] GLYPH [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH
    } state_t;

endpackage

// File: rtl/seg_glyph_dec.sv
// Maps one active-low 7-segment glyph back to its hex nibble; unknown
// patterns decode to nibble 0 with ok low.
module seg_glyph_dec (
    input  logic [6:0] glyph,
    output logic       ok,
    output logic [3:0] nibble
);
    import seg_pkg::*;

    always_comb begin
        ok     = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (glyph == GLYPH[i]) begin
                ok     = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_s2p_rx.sv
// Serial-to-parallel receiver for a 64-bit 7-segment display frame: samples
// the serial bus in the clk domain, latches on SEG_EN and decodes to hex.
module seg_s2p_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = seg_pkg::FRAME_BITS
) (
    input  logic                    clk,
    input  logic                    RSTN,
    input  logic                    SEG_CLK,
    input  logic                    SEG_DT,
    input  logic                    SEG_EN,
    input  logic                    SEG_CLR,
    output logic [FRAME_BITS-1:0]   frame,
    output logic [FRAME_BITS/2-1:0] num,
    output logic [FRAME_BITS/8-1:0] point,
    output logic [FRAME_BITS/8-1:0] hex_ok,
    output logic                    frame_valid,
    output logic                    len_err
);
    import seg_pkg::*;

    localparam int DIGITS = FRAME_BITS / 8;

    // Bit order in each stage: {CLR, EN, DT, CLK}
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]                  prev_q;
    logic [3:0]                  sync_s;
    logic                        clk_rise, en_rise, dt_s, clr_n;
    logic                        unused_prev;

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {SEG_CLR, SEG_EN, SEG_DT, SEG_CLK}};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_s      = sync_q[SYNC_STAGES-1];
    assign clk_rise    = sync_s[0] & ~prev_q[0];
    assign dt_s        = sync_s[1];
    assign en_rise     = sync_s[2] & ~prev_q[2];
    assign clr_n       = sync_s[3];
    assign unused_prev = ^{prev_q[3], prev_q[1]};

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (!RSTN) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en_rise)       state_d = ST_LATCH;
                else if (clk_rise) state_d = ST_SHIFT;
            end
            ST_SHIFT: if (en_rise) state_d = ST_LATCH;
            ST_LATCH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (!clr_n) state_d = ST_IDLE;
    end

    logic [FRAME_BITS-1:0]   shreg;
    logic [6:0]              bit_cnt;
    logic [DIGITS-1:0]       dec_ok;
    logic [DIGITS-1:0]       dec_dp;
    logic [FRAME_BITS/2-1:0] dec_num;

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        seg_glyph_dec u_dec (
            .glyph  (shreg[8*k +: 7]),
            .ok     (dec_ok[k]),
            .nibble (dec_num[4*k +: 4])
        );
        assign dec_dp[k] = ~shreg[8*k+7];
    end

    // The LATCH cycle sees shreg after any shift from the cycle that raised
    // SEG_EN, so a coincident clock edge is already included.
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            shreg       <= '1;
            bit_cnt     <= '0;
            frame       <= '1;
            num         <= '0;
            point       <= '0;
            hex_ok      <= '0;
            frame_valid <= 1'b0;
            len_err     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (!clr_n) begin
                shreg   <= '1;
                bit_cnt <= '0;
            end else begin
                if (clk_rise) begin
                    shreg <= {shreg[FRAME_BITS-2:0], dt_s};
                    if (bit_cnt != 7'h7F) bit_cnt <= bit_cnt + 7'd1;
                end
                if (state_q == ST_LATCH) begin
                    frame       <= shreg;
                    num         <= dec_num;
                    point       <= dec_dp;
                    hex_ok      <= dec_ok;
                    frame_valid <= 1'b1;
                    bit_cnt     <= '0;
                    if (bit_cnt != 7'(FRAME_BITS)) len_err <= 1'b1;
                end
            end
        end
    end

endmodule
